// File: rtl/rr_dreg_mux_if.sv
// Bundle of requester-side and consumer-side signals for rr_dreg_mux.
// The arbiter takes the slave view. The producer/consumer (or a bench) takes the master view.
interface rr_dreg_mux_if #(
  parameter int DIN = 16,
  parameter int NUM = 4
);
  localparam int IW = $clog2(NUM);

  logic [NUM-1:0]     din_valid;
  logic [NUM*DIN-1:0] din_data;
  logic [NUM-1:0]     din_ready;
  logic               dout_valid;
  logic               dout_ready;
  logic [DIN-1:0]     dout_data;
  logic [IW-1:0]      dout_idx;

  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data, dout_idx
  );

  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data, dout_idx
  );
endinterface

// File: rtl/rr_dreg_mux.sv
// Round-robin N:1 arbiter feeding a single decoupling register (data, idx, valid).
// The grant is combinational from ptr_q and din_valid. The winner loads the register one edge later.
// Optional packet locking is enabled by defining RR_DREG_MUX_EOT_LOCK_EN.
// In that mode, the data MSB is the end-of-packet flag, and the grant stays on one
// requester until that requester transfers a word with the flag set.
module rr_dreg_mux #(
  parameter int DIN = 16,
  parameter int NUM = 4
) (
  input logic          clk,
  input logic          rst,
  rr_dreg_mux_if.slave bus
);
  localparam int IW = $clog2(NUM);

  logic               dout_valid_q, dout_valid_d;
  logic [DIN-1:0]     dout_data_q, dout_data_d;
  logic [IW-1:0]      dout_idx_q, dout_idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;

  logic               reg_ready;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic               gnt_ok;
  logic [IW-1:0]      gnt_idx;
  logic [DIN-1:0]     gnt_data;
  logic [IW-1:0]      ptr_next;
  logic [DIN-1:0]     din_arr [NUM];

`ifdef RR_DREG_MUX_EOT_LOCK_EN
  logic               lock_q, lock_d;
  logic [IW-1:0]      lock_idx_q, lock_idx_d;
`endif

  // Index that is k places above base, wrapping modulo NUM (NUM need not be a power of two).
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM) s = s - NUM;
    return IW'(s);
  endfunction

  assign reg_ready = !dout_valid_q || bus.dout_ready;

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      din_arr[i] = bus.din_data[i*DIN +: DIN];
    end
  end

  // First valid requester at or above ptr_q. The loop scans downward so the lowest offset wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (bus.din_valid[rot_idx(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rot_idx(ptr_q, k);
      end
    end
  end

  // Select the grant target. While locked, only the locked requester can win, even if it is idle.
  always_comb begin
    gnt_idx = win_idx;
    gnt_ok  = win_found;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
    if (lock_q) begin
      gnt_idx = lock_idx_q;
      gnt_ok  = bus.din_valid[lock_idx_q];
    end
`endif
  end

  assign gnt_data = din_arr[gnt_idx];
  assign ptr_next = (gnt_idx == IW'(NUM - 1)) ? '0 : gnt_idx + 1'b1;

  // Raise ready for the winner only, and only when the register can accept a word.
  always_comb begin
    bus.din_ready = '0;
    if (!rst && reg_ready && gnt_ok) bus.din_ready[gnt_idx] = 1'b1;
  end

  // Compute the next state of the register, the pointer and the lock.
  always_comb begin
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_idx_d   = dout_idx_q;
    ptr_d        = ptr_q;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
`endif
    if (reg_ready) begin
      dout_valid_d = gnt_ok;
      if (gnt_ok) begin
        dout_data_d = gnt_data;
        dout_idx_d  = gnt_idx;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
        if (gnt_data[DIN-1]) begin
          ptr_d  = ptr_next;
          lock_d = 1'b0;
        end else begin
          lock_d     = 1'b1;
          lock_idx_d = gnt_idx;
        end
`else
        ptr_d = ptr_next;
`endif
      end
    end
  end

  // Control state: valid, pointer and lock are cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid_q <= 1'b0;
      ptr_q        <= '0;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      dout_valid_q <= dout_valid_d;
      ptr_q        <= ptr_d;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  // Datapath registers have no reset. Their contents are meaningless while dout_valid_q is low.
  always_ff @(posedge clk) begin
    dout_data_q <= dout_data_d;
    dout_idx_q  <= dout_idx_d;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
    lock_idx_q  <= lock_idx_d;
`endif
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;
  assign bus.dout_idx   = dout_idx_q;

endmodule

// File: tb/tb_rr_dreg_mux.sv
// Self-checking bench for rr_dreg_mux.
// The DUT is checked every cycle against a behavioural round-robin model.
// Literal checks pin the model to known sequences.
module tb_rr_dreg_mux;
  localparam int DIN = 16;
  localparam int NUM = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_dreg_mux_if #(.DIN(DIN), .NUM(NUM)) bus ();
  rr_dreg_mux #(.DIN(DIN), .NUM(NUM)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  bit             m_valid = 1'b0;
  logic [DIN-1:0] m_data  = '0;
  int             m_idx   = 0;
  int             m_ptr   = 0;
  bit             m_lock  = 1'b0;
  int             m_lock_idx = 0;

  int             acc_idx[$];
  logic [NUM-1:0] seen_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DIN-1:0] word_of(input int i);
    return bus.din_data[i*DIN +: DIN];
  endfunction

  // Find the requester that must win right now, or -1 if none.
  function automatic int m_winner();
    if (m_lock) return bus.din_valid[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 0; k < NUM; k++) begin
      if (bus.din_valid[(m_ptr + k) % NUM]) return (m_ptr + k) % NUM;
    end
    return -1;
  endfunction

  // Run one clock cycle.
  // At the negedge, compare the DUT outputs with the model.
  // At the posedge, advance the model, then wait #1 so the caller can drive new inputs.
  task automatic cycle();
    int w;
    bit rr;
    logic [NUM-1:0] er;
    @(negedge clk);
    rr = !m_valid || bus.dout_ready;
    w  = m_winner();
    er = '0;
    if (!rst && rr && w >= 0) er[w] = 1'b1;
    check("din_ready", bus.din_ready, er);
    check("dout_valid", bus.dout_valid, m_valid);
    if (m_valid) begin
      check("dout_data", bus.dout_data, m_data);
      check("dout_idx", bus.dout_idx, m_idx);
    end
    seen_ready = bus.din_ready;
    if (bus.dout_valid && bus.dout_ready) acc_idx.push_back(int'(bus.dout_idx));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      m_lock  = 1'b0;
    end else if (rr) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = word_of(w);
        m_idx   = w;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
        if (m_data[DIN-1]) begin
          m_ptr  = (w + 1) % NUM;
          m_lock = 1'b0;
        end else begin
          m_lock     = 1'b1;
          m_lock_idx = w;
        end
`else
        m_ptr = (w + 1) % NUM;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  // Fill every data word with a random value whose MSB (the end-of-packet bit) is set.
  task automatic fill_eot_data();
    for (int i = 0; i < NUM; i++) bus.din_data[i*DIN +: DIN] = {1'b1, 15'($urandom)};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.din_valid  = '0;
    bus.dout_ready = 1'b0;
    fill_eot_data();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e032 [5];
    int hidx;
    logic [DIN-1:0] held;
    int sent;
    bit gap_done;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
    int eseq [5];
    eseq = '{0, 1, 1, 1, 0};
`else
    int eseq [6];
    eseq = '{0, 1, 0, 1, 0, 1};
`endif
    e032 = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    bus.din_valid  = '0;
    bus.din_data   = '0;
    bus.dout_ready = 1'b0;
    @(posedge clk);
    #1;

    // All requesters valid and the consumer always ready: round-robin order 0,1,2,3,0.
    do_reset();
    check("reset_dout_valid", bus.dout_valid, 1'b0);
    acc_idx.delete();
    bus.din_valid  = '1;
    bus.dout_ready = 1'b1;
    repeat (6) cycle();
    for (int i = 0; i < 5; i++)
      check("rr_seq", (i < acc_idx.size()) ? acc_idx[i] : -1, e032[i]);

    // A single requester (2) with data 0x00AB: the word appears one cycle later,
    // and the next search starts from requester 3.
    do_reset();
    bus.din_valid  = 4'b0100;
    bus.din_data[2*DIN +: DIN] = 16'h00AB;
    bus.dout_ready = 1'b1;
    cycle();
    check("single_valid", bus.dout_valid, 1'b1);
    check("single_data", bus.dout_data, 16'h00AB);
    check("single_idx", bus.dout_idx, 2);
    bus.din_valid = '1;
    cycle();
`ifdef RR_DREG_MUX_EOT_LOCK_EN
    check("single_next", bus.dout_idx, 2);
`else
    check("single_next", bus.dout_idx, 3);
`endif

    // Backpressure for 3 cycles with the register full, then release.
    do_reset();
    bus.din_valid  = '1;
    bus.dout_ready = 1'b1;
    repeat (3) cycle();
    bus.dout_ready = 1'b0;
    held = bus.dout_data;
    hidx = int'(bus.dout_idx);
    repeat (3) begin
      cycle();
      check("stall_ready", seen_ready, '0);
      check("stall_data", bus.dout_data, held);
    end
    acc_idx.delete();
    bus.dout_ready = 1'b1;
    repeat (5) cycle();
    check("release_count", acc_idx.size(), 5);
    for (int i = 0; i < 5; i++)
      check("release_seq", (i < acc_idx.size()) ? acc_idx[i] : -1, (hidx + i) % NUM);

    // Reset pulse while the register is full and ptr is 3: the word is discarded,
    // and the first grant afterwards goes to requester 0.
    do_reset();
    bus.din_valid  = 4'b0100;
    bus.dout_ready = 1'b0;
    cycle();
    check("pre_rst_valid", bus.dout_valid, 1'b1);
    rst = 1'b1;
    bus.din_valid = '1;
    cycle();
    check("post_rst_valid", bus.dout_valid, 1'b0);
    rst = 1'b0;
    bus.dout_ready = 1'b1;
    cycle();
    check("post_rst_valid2", bus.dout_valid, 1'b1);
    check("post_rst_idx", bus.dout_idx, 0);

    // Requester 1 sends a 3-word packet while requester 0 stays valid.
    // First, one word from requester 0 moves ptr to 1.
    do_reset();
    bus.dout_ready = 1'b1;
    bus.din_valid  = 4'b0001;
    cycle();
    acc_idx.delete();
    sent = 0;
    gap_done = 1'b0;
    repeat (10) begin
      bus.din_valid[0] = 1'b1;
`ifdef RR_DREG_MUX_EOT_LOCK_EN
      bus.din_valid[1] = (sent < 3) && !(sent == 1 && !gap_done);
      if (sent == 1 && !gap_done) gap_done = 1'b1;
`else
      bus.din_valid[1] = (sent < 3);
`endif
      bus.din_data[1*DIN +: DIN] = {(sent == 2), 15'(sent)};
      cycle();
      if (bus.din_valid[1] && seen_ready[1]) sent++;
    end
    for (int i = 0; i < $size(eseq); i++)
      check("pkt_seq", (i < acc_idx.size()) ? acc_idx[i] : -1, eseq[i]);

    // Random traffic: valids, data, backpressure and occasional resets.
    do_reset();
    repeat (3000) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.din_valid  = NUM'($urandom);
      bus.din_data   = {$urandom, $urandom};
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_dreg_mux.md
RR_DREG_MUX -- requirements
Module: rr_dreg_mux

Interface
REQ-001 Parameter DIN, default 16: data width per requester, 1..256.
REQ-002 Parameter NUM, default 4: number of requesters, 2..8.
REQ-003 Parameter IW, derived as $clog2(NUM): width of the index field.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din_valid  input  NUM  per-requester valid; bit i belongs to requester i.
REQ-007 din_data  input  NUM*DIN  per-requester data; requester i occupies bits [i*DIN +: DIN].
REQ-008 din_ready  output  NUM  per-requester ready.
REQ-009 dout_valid  output  1  register holds a word.
REQ-010 dout_ready  input  1  consumer accepts the word.
REQ-011 dout_data  output  DIN  registered winning data.
REQ-012 dout_idx  output  IW  registered index of the requester that supplied dout_data.

Function
REQ-013 The block SHALL contain one decoupling register (data, idx, valid).
REQ-014 reg_ready = !dout_valid | dout_ready.
REQ-015 The winner SHALL be the first requester with valid set, searching from ptr upward modulo NUM; the grant is combinational.
REQ-016 din_ready[i] SHALL be 1 only for the winner, and only while reg_ready is 1; every other bit SHALL be 0.
REQ-017 din_ready SHALL be all zeros when no valid bit is set.
REQ-018 A transfer occurs when din_valid[w] & din_ready[w]; the register then SHALL load data[w] and w, with valid = 1, on that edge (latency 1).
REQ-019 When reg_ready = 1 and no requester is valid, the register valid SHALL load 0.
REQ-020 When reg_ready = 0, the register SHALL hold its contents and all din_ready bits SHALL be 0.
REQ-021 After a transfer from w, ptr SHALL become (w+1) mod NUM; it wraps from NUM-1 to 0.
REQ-022 Without a transfer, ptr SHALL hold its value.
REQ-023 A requester SHALL NOT be granted twice in a row while another requester is valid (non-locked mode).
REQ-024 Simultaneous drain and fill (dout_ready = 1 with a new transfer in the same cycle) SHALL sustain 1 word per cycle with no bubble.
REQ-025 A requester dropping valid before it is granted SHALL lose no data and SHALL NOT move ptr.

Reset
REQ-026 While rst = 1: dout_valid = 0, ptr = 0, lock = 0, and din_ready = 0 from the first rising edge onward.
REQ-027 dout_data and dout_idx are unspecified after reset; the bench SHALL ignore them while dout_valid = 0.
REQ-028 Reset asserted mid-operation SHALL discard the held word; the first grant after reset SHALL start from requester 0.

Configuration
REQ-029 Macro RR_DREG_MUX_EOT_LOCK_EN SHALL enable packet locking.
REQ-030 When the macro is defined: the MSB of each requester's data is its end-of-packet flag.
  - A transfer with EOT = 0 SHALL set lock and hold the grant on w.
  - ptr SHALL advance only on a transfer with EOT = 1, which also clears lock.
  - While locked, other requesters SHALL get din_ready = 0 even when w has valid = 0.
REQ-031 When the macro is undefined: no lock state exists, and REQ-021 applies on every transfer.

Verification
REQ-032 After reset, NUM=4 with all valid and dout_ready held at 1 -> dout_idx sequence 0,1,2,3,0; dout_valid is 1 from the cycle after the first grant.
REQ-033 Only requester 2 valid, with data 0x00AB -> one cycle later dout_valid = 1, dout_data = 0x00AB, dout_idx = 2; next winner search starts at 3.
REQ-034 Register full and dout_ready = 0 for 3 cycles with all valid -> din_ready = 0 and dout_data stable for those 3 cycles; on release, exactly one word per cycle with no loss.
REQ-035 rst pulsed for 1 cycle while dout_valid = 1 and ptr = 3 -> next cycle dout_valid = 0; the first grant afterward goes to requester 0.
REQ-036 With the macro defined: requester 1 sends 3 words with EOT on the last only, requester 0 continuously valid -> dout_idx sequence 1,1,1,0, including through a 1-cycle valid gap from requester 1.
REQ-037 With the macro undefined, same stimulus as REQ-036 -> dout_idx alternates 1,0,1,0,1.
